// File: rtl/pipes_pkg.sv
// Shared pipeline types: opcode constants, bypass channel and decode output records.
// Record datapaths are PIPE_XLEN wide; modules with a narrower XLEN use the low bits.
package pipes_pkg;

    localparam int PIPE_XLEN = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic                 valid;
        logic                 ismem;
        logic [4:0]           dst;
        logic [PIPE_XLEN-1:0] data;
    } fwd_chan_t;

    typedef struct packed {
        logic                 valid;
        logic [PIPE_XLEN-1:0] pc;
        logic [31:0]          instr;
        logic [4:0]           dst;
        logic                 wr;
        logic [PIPE_XLEN-1:0] rd1;
        logic [PIPE_XLEN-1:0] rd2;
    } decode_out_t;

    // Stores and branches never write rd; x0 writes are dropped.
    function automatic logic writes_rd(input logic [31:0] instr);
        return (instr[6:0] != OP_STORE) && (instr[6:0] != OP_BRANCH) && (instr[11:7] != 5'd0);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO holding fetched {pc, instr} entries; flush empties it and drops
// any push on the same edge.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             head_valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign rdata      = mem[rd_ptr];
    assign do_push    = push && !full && !flush;
    assign do_pop     = pop && head_valid && !flush;

    // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/decode_fwd.sv
// Decode stage: fetch queue, operand bypass from NFWD channels (index 0 youngest),
// load-use/memory hazard stall and a single output register.
module decode_fwd
    import pipes_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NFWD   = 3,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    input  logic              hold,
    input  logic [NFWD-1:0]   fwd_valid,
    input  logic [NFWD-1:0]   fwd_ismem,
    input  logic [NFWD*5-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    input  logic [XLEN-1:0]   q1,
    input  logic [XLEN-1:0]   q2,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic [4:0]        out_dst,
    output logic              out_wr,
    output logic [XLEN-1:0]   out_rd1,
    output logic [XLEN-1:0]   out_rd2,
    output logic [31:0]       stall_cnt
);

    localparam int EW = XLEN + 32;

    // Handshakes: a fetch transfers on an edge with in_valid && in_ready; the output
    // register is taken downstream on an edge with out_valid && !hold, and stays put while hold=1.
    logic [EW-1:0]   head;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;
    logic            head_valid;
    logic            full;
    logic            push;
    logic            pop;
    logic            hazard;
    logic            pend1;
    logic            pend2;
    logic [PIPE_XLEN-1:0] rd1;
    logic [PIPE_XLEN-1:0] rd2;
    fwd_chan_t       chan [NFWD];
    decode_out_t     out_r;
    decode_out_t     next_out;

    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    assign {head_pc, head_instr} = head;
    assign rs1 = head_instr[19:15];
    assign rs2 = head_instr[24:20];

    fetch_queue #(.DEPTH(QDEPTH), .WIDTH(EW)) u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .wdata      ({in_pc, in_instr}),
        .rdata      (head),
        .head_valid (head_valid),
        .full       (full)
    );

    always_comb begin
        for (int i = 0; i < NFWD; i++) begin
            chan[i].valid = fwd_valid[i];
            chan[i].ismem = fwd_ismem[i];
            chan[i].dst   = fwd_dst[i*5 +: 5];
            chan[i].data  = PIPE_XLEN'(fwd_data[i*XLEN +: XLEN]);
        end
    end

    // Walk from oldest to youngest so the lowest-index match wins.
    always_comb begin
        rd1   = PIPE_XLEN'(q1);
        rd2   = PIPE_XLEN'(q2);
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (chan[i].valid && chan[i].dst == rs1) begin
                rd1   = chan[i].data;
                pend1 = chan[i].ismem;
            end
            if (chan[i].valid && chan[i].dst == rs2) begin
                rd2   = chan[i].data;
                pend2 = chan[i].ismem;
            end
        end
        if (rs1 == 5'd0) begin
            rd1   = PIPE_XLEN'(q1);
            pend1 = 1'b0;
        end
        if (rs2 == 5'd0) begin
            rd2   = PIPE_XLEN'(q2);
            pend2 = 1'b0;
        end
    end

    assign hazard = pend1 || pend2 ||
                    (out_r.valid && out_r.wr &&
                     ((rs1 != 5'd0 && rs1 == out_r.dst) || (rs2 != 5'd0 && rs2 == out_r.dst)));

    assign pop = head_valid && !hazard && !hold && !flush;

    always_comb begin
        next_out       = '0;
        next_out.valid = head_valid && !hazard;
        next_out.pc    = PIPE_XLEN'(head_pc);
        next_out.instr = head_instr;
        next_out.dst   = head_instr[11:7];
        next_out.wr    = writes_rd(head_instr);
        next_out.rd1   = rd1;
        next_out.rd2   = rd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r     <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush)      out_r.valid <= 1'b0;
            else if (!hold) out_r       <= next_out;
            if (head_valid && hazard && !hold && !flush && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign out_valid = out_r.valid;
    assign out_pc    = out_r.pc[XLEN-1:0];
    assign out_instr = out_r.instr;
    assign out_dst   = out_r.dst;
    assign out_wr    = out_r.wr;
    assign out_rd1   = out_r.rd1[XLEN-1:0];
    assign out_rd2   = out_r.rd2[XLEN-1:0];

endmodule
